// File: rtl/axi_write_subsystem_if.sv
// Requester-facing bundle of axi_write_subsystem: write requests in,
// memory readback and burst status out.
interface axi_write_subsystem_if;
    logic        memoryWrite;
    logic [31:0] Datain;
    logic [31:0] WADDR;
    logic [3:0]  ID;
    logic [3:0]  WWID;
    logic [3:0]  WLEN;
    logic [2:0]  WSIZE;
    logic [1:0]  WBURST;
    logic [1:0]  WLOCK;
    logic [3:0]  WCACHE;
    logic [2:0]  WPROT;
    logic        cs;
    logic [6:0]  readaddy;
    logic [31:0] readdata;
    logic [1:0]  response;
    logic        resp_valid;
    logic        busy;

    modport master (
        output memoryWrite, Datain, WADDR, ID, WWID, WLEN, WSIZE, WBURST,
        output WLOCK, WCACHE, WPROT, cs, readaddy,
        input  readdata, response, resp_valid, busy
    );

    modport slave (
        input  memoryWrite, Datain, WADDR, ID, WWID, WLEN, WSIZE, WBURST,
        input  WLOCK, WCACHE, WPROT, cs, readaddy,
        output readdata, response, resp_valid, busy
    );
endinterface

// File: rtl/axi_write_subsystem.sv
// AXI3 write path: request FIFO -> write master -> write slave -> 128x32 memory,
// with an independent chip-selected read port.
module axi_write_subsystem (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_write_subsystem_if.slave  req
);
    typedef struct packed {
        logic [31:0] data;
        logic [6:0]  addr;
        logic [3:0]  id;
        logic [3:0]  wid;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
    } req_t;

    typedef enum logic [1:0] {M_IDLE, M_ADDR, M_DATA, M_RESP} m_state_t;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_WAIT, S_RESP} s_state_t;

    // Internal AXI write channels
    logic        awvalid, awready;
    logic [3:0]  awid, awlen, awcache;
    logic [6:0]  awaddr;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        wvalid, wready, wlast;
    logic [3:0]  wid, wstrb;
    logic [31:0] wdata;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    // ---------------- request capture FIFO ----------------
    logic       mw_d_reg;
    logic       push, push_ok, pop;
    logic       fifo_empty, fifo_full;
    logic [1:0] wr_ptr_reg, rd_ptr_reg;
    logic [2:0] count_reg;
    req_t       fifo_mem [4];
    req_t       new_req;

    assign push       = req.memoryWrite & ~mw_d_reg;
    assign fifo_empty = (count_reg == 3'd0);
    assign fifo_full  = (count_reg == 3'd4);
    assign push_ok    = push & (~fifo_full | pop);
    assign new_req    = '{data: req.Datain, addr: req.WADDR[6:0], id: req.ID, wid: req.WWID,
                          len: req.WLEN, size: req.WSIZE, burst: req.WBURST, lock: req.WLOCK,
                          cache: req.WCACHE, prot: req.WPROT};

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            mw_d_reg   <= 1'b0;
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            mw_d_reg <= req.memoryWrite;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 2'd1;
            count_reg <= count_reg + {2'b00, push_ok} - {2'b00, pop};
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_ok) fifo_mem[wr_ptr_reg] <= new_req;
    end

    // ---------------- write master ----------------
    m_state_t    m_state_reg, m_state_next;
    req_t        cur_reg;
    logic [3:0]  beat_reg;
    logic [1:0]  response_reg;
    logic        resp_valid_reg;

    always_comb begin
        m_state_next = m_state_reg;
        pop     = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (m_state_reg)
            M_IDLE: if (!fifo_empty) begin
                pop          = 1'b1;
                m_state_next = M_ADDR;
            end
            M_ADDR: begin
                awvalid = 1'b1;
                if (awready) m_state_next = M_DATA;
            end
            M_DATA: begin
                wvalid = 1'b1;
                if (wready && wlast) m_state_next = M_RESP;
            end
            M_RESP: begin
                bready = 1'b1;
                if (bvalid) m_state_next = M_IDLE;
            end
            default: m_state_next = M_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            m_state_reg    <= M_IDLE;
            cur_reg        <= '0;
            beat_reg       <= 4'd0;
            response_reg   <= 2'b00;
            resp_valid_reg <= 1'b0;
        end else begin
            m_state_reg    <= m_state_next;
            resp_valid_reg <= 1'b0;
            if (pop) begin
                cur_reg  <= fifo_mem[rd_ptr_reg];
                beat_reg <= 4'd0;
            end
            if (wvalid && wready) beat_reg <= beat_reg + 4'd1;
            if (bready && bvalid) begin
                response_reg   <= bresp;
                resp_valid_reg <= 1'b1;
            end
        end
    end

    // Channel payloads come straight from the popped request, so they stay stable under stall.
    assign awid    = cur_reg.id;
    assign awaddr  = cur_reg.addr;
    assign awlen   = cur_reg.len;
    assign awsize  = cur_reg.size;
    assign awburst = cur_reg.burst;
    assign awlock  = cur_reg.lock;
    assign awcache = cur_reg.cache;
    assign awprot  = cur_reg.prot;
    assign wdata   = cur_reg.data;
    assign wid     = cur_reg.wid;
    assign wstrb   = 4'hF;
    assign wlast   = (m_state_reg == M_DATA) && (beat_reg == cur_reg.len);

    // ---------------- write slave ----------------
    s_state_t    s_state_reg, s_state_next;
    logic [3:0]  awid_reg, awlen_reg, sbeat_reg;
    logic [1:0]  awburst_reg;
    logic [6:0]  addr_reg, next_addr, addr_inc, wrap_mask;
    logic        err_reg, last_reg;
    logic        mem_req_reg, mem_we_reg, mem_done_reg;
    logic [6:0]  mem_waddr_reg;
    logic [31:0] mem_wdata_reg;
    logic        beat_end;

    assign awready   = (s_state_reg == S_IDLE);
    assign wready    = (s_state_reg == S_DATA);
    assign bvalid    = (s_state_reg == S_RESP);
    assign bid       = awid_reg;
    assign bresp     = err_reg ? 2'b10 : 2'b00;
    assign beat_end  = wlast | (sbeat_reg == awlen_reg);
    assign addr_inc  = addr_reg + 7'd1;
    assign wrap_mask = {3'b000, awlen_reg};

    always_comb begin
        case (awburst_reg)
            2'b01:   next_addr = addr_inc;
            2'b10:   next_addr = (addr_reg & ~wrap_mask) | (addr_inc & wrap_mask);
            default: next_addr = addr_reg;
        endcase
    end

    always_comb begin
        s_state_next = s_state_reg;
        case (s_state_reg)
            S_IDLE:  if (awvalid) s_state_next = S_DATA;
            S_DATA:  if (wvalid) s_state_next = S_WAIT;
            S_WAIT:  if (mem_done_reg) s_state_next = last_reg ? S_RESP : S_DATA;
            S_RESP:  if (bready) s_state_next = S_IDLE;
            default: s_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            s_state_reg   <= S_IDLE;
            awid_reg      <= 4'd0;
            awlen_reg     <= 4'd0;
            awburst_reg   <= 2'b00;
            addr_reg      <= 7'd0;
            sbeat_reg     <= 4'd0;
            err_reg       <= 1'b0;
            last_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_waddr_reg <= 7'd0;
            mem_wdata_reg <= 32'd0;
        end else begin
            s_state_reg <= s_state_next;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            if (s_state_reg == S_IDLE && awvalid) begin
                awid_reg    <= awid;
                awlen_reg   <= awlen;
                awburst_reg <= awburst;
                addr_reg    <= awaddr;
                sbeat_reg   <= 4'd0;
                err_reg     <= (awburst == 2'b11);
            end
            if (s_state_reg == S_DATA && wvalid) begin
                // A mismatched WID still takes a memory slot so the finish pulse keeps the burst moving.
                mem_req_reg   <= 1'b1;
                mem_we_reg    <= (wid == awid_reg);
                mem_waddr_reg <= addr_reg;
                mem_wdata_reg <= wdata;
                addr_reg      <= next_addr;
                sbeat_reg     <= sbeat_reg + 4'd1;
                last_reg      <= beat_end;
                if ((wid != awid_reg) || (wlast != (sbeat_reg == awlen_reg))) err_reg <= 1'b1;
            end
        end
    end

    // ---------------- memory ----------------
    logic [31:0] mem [128];
    logic [31:0] readdata_reg;

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
            mem_done_reg <= 1'b0;
            readdata_reg <= 32'd0;
        end else begin
            mem_done_reg <= mem_req_reg;
            if (mem_we_reg && req.cs) mem[mem_waddr_reg] <= mem_wdata_reg;
            if (req.cs) readdata_reg <= mem[req.readaddy];
        end
    end

    assign req.readdata   = readdata_reg;
    assign req.response   = response_reg;
    assign req.resp_valid = resp_valid_reg;
    assign req.busy       = !fifo_empty || (m_state_reg != M_IDLE);

    logic unused_ok;
    assign unused_ok = ^{req.WADDR[31:7], awsize, awlock, awcache, awprot, wstrb, bid};
endmodule

// File: tb/tb_axi_write_subsystem.sv
// Scoreboarded random/directed bench for axi_write_subsystem; a reference memory
// model tracks every accepted burst, a monitor checks each B response.
module tb_axi_write_subsystem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_write_subsystem_if bus();
    axi_write_subsystem dut (.ACLK(clk), .ARESETn(rst), .req(bus));

    typedef struct {
        logic [1:0] resp;
        int         beats;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model_mem [128];
    int total = 0, bad = 0;
    int cyc = 0, outstanding = 0, resp_seen = 0;
    int last_resp_cyc = 0, last_req_cyc = 0;
    int beat_cnt = 0, last_pos = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: counts W beats and pops one expectation per B response.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (dut.wvalid && dut.wready) begin
                beat_cnt++;
                if (dut.wlast) last_pos = beat_cnt;
            end
            if (bus.resp_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got resp %0h expected no response", bus.response);
                end else begin
                    e = sbq.pop_front();
                    check("bresp", bus.response, e.resp);
                    check("beat_count", beat_cnt, e.beats);
                    check("wlast_pos", last_pos, e.beats);
                end
                beat_cnt = 0;
                last_pos = 0;
                outstanding--;
                resp_seen++;
                last_resp_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [6:0] a, input logic [3:0] len, input logic [1:0] bt,
                        input logic [31:0] d, input logic [3:0] id, input logic [3:0] wid,
                        input bit accept);
        exp_t e;
        logic [31:0] r;
        int av, sz, ad;
        r = $urandom();
        @(posedge clk); #1;
        bus.WADDR       = {r[31:7], a};
        bus.Datain      = d;
        bus.ID          = id;
        bus.WWID        = wid;
        bus.WLEN        = len;
        bus.WSIZE       = 3'd2;
        bus.WBURST      = bt;
        bus.WLOCK       = r[1:0];
        bus.WCACHE      = r[5:2];
        bus.WPROT       = r[6:4];
        bus.memoryWrite = 1'b1;
        last_req_cyc    = cyc + 1;
        @(posedge clk); #1;
        bus.memoryWrite = 1'b0;
        $display("req addr=%0d len=%0d burst=%0d data=%0h id=%0d wid=%0d accept=%0b",
                 a, len, bt, d, id, wid, accept);
        if (accept) begin
            av = int'(a);
            sz = int'(len) + 1;
            for (int i = 0; i < sz; i++) begin
                case (bt)
                    2'b01:   ad = (av + i) % 128;
                    2'b10:   ad = (av - (av % sz)) + ((av % sz) + i) % sz;
                    default: ad = av;
                endcase
                if (wid == id) model_mem[ad] = d;
            end
            e.resp  = (bt == 2'b11 || wid != id) ? 2'b10 : 2'b00;
            e.beats = sz;
            sbq.push_back(e);
            outstanding++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((outstanding != 0 || bus.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0b outstanding=%0d expected idle", bus.busy, outstanding);
        end
        @(negedge clk);
    endtask

    task automatic rd_check(input logic [6:0] a);
        @(posedge clk); #1;
        bus.cs       = 1'b1;
        bus.readaddy = a;
        @(posedge clk); #1;
        check($sformatf("mem[%0d]", a), bus.readdata, model_mem[a]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    initial begin
        int n, rs;
        logic [3:0] rid, rlen;
        logic [1:0] rbt;
        for (int i = 0; i < 128; i++) model_mem[i] = 32'd0;
        bus.memoryWrite = 0; bus.Datain = 0; bus.WADDR = 0; bus.ID = 0; bus.WWID = 0;
        bus.WLEN = 0; bus.WSIZE = 0; bus.WBURST = 0; bus.WLOCK = 0; bus.WCACHE = 0;
        bus.WPROT = 0; bus.cs = 1; bus.readaddy = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readdata", bus.readdata, 0);
        check("rst_response", bus.response, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_awvalid", dut.awvalid, 0);
        check("rst_wvalid", dut.wvalid, 0);
        @(posedge clk); #1 rst = 1'b0;
        rd_check(7'd2);

        // Single FIXED burst
        send(7'd2, 4'd3, 2'b00, 32'd1, 4'd5, 4'd5, 1'b1);
        wait_idle();
        check("latency_le_20", (last_resp_cyc - last_req_cyc) <= 20, 1);
        rd_check(7'd2);
        rd_check(7'd3);

        // Three queued requests
        for (int k = 1; k <= 3; k++) begin
            send(7'd2, 4'd3, 2'b00, 32'(k), 4'd1, 4'd1, 1'b1);
            @(posedge clk);
        end
        wait_idle();
        check("busy_after_drain", bus.busy, 0);
        rd_check(7'd2);

        // INCR across the top of memory
        send(7'd126, 4'd3, 2'b01, 32'd7, 4'd2, 4'd2, 1'b1);
        wait_idle();
        rd_check(7'd126); rd_check(7'd127); rd_check(7'd0); rd_check(7'd1);

        // WRAP inside a 4-word block
        send(7'd5, 4'd3, 2'b10, 32'd9, 4'd3, 4'd3, 1'b1);
        wait_idle();
        rd_check(7'd5); rd_check(7'd6); rd_check(7'd7); rd_check(7'd4); rd_check(7'd8);

        // Reserved burst type, then WID mismatch
        send(7'd10, 4'd1, 2'b11, 32'hAB, 4'd2, 4'd2, 1'b1);
        send(7'd20, 4'd2, 2'b01, 32'h55, 4'd3, 4'd4, 1'b1);
        wait_idle();
        rd_check(7'd10); rd_check(7'd20); rd_check(7'd21);

        // Read port: cs low holds, cs high returns after one cycle
        rd_check(7'd5);
        @(posedge clk); #1;
        bus.cs = 1'b0;
        bus.readaddy = 7'd2;
        @(posedge clk); #1;
        check("cs0_hold", bus.readdata, model_mem[5]);
        bus.cs = 1'b1;
        @(posedge clk); #1;
        check("cs1_read", bus.readdata, model_mem[2]);

        // Overflow: long burst in flight, six more edges, only four fit
        rs = resp_seen;
        send(7'd30, 4'd15, 2'b01, 32'hC0DE, 4'd6, 4'd6, 1'b1);
        repeat (3) @(posedge clk);
        for (int k = 0; k < 6; k++)
            send(7'(50 + k), 4'd0, 2'b01, 32'h100 + 32'(k), 4'd7, 4'd7, k < 4);
        wait_idle();
        check("overflow_responses", resp_seen - rs, 5);
        for (int k = 0; k < 6; k++) rd_check(7'(50 + k));

        // Randomized traffic, kept within queue capacity
        for (int t = 0; t < 30; t++) begin
            n = 0;
            while (outstanding >= 4 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000) begin
                total++;
                bad++;
                $display("FAIL queue_wait_timeout: outstanding=%0d expected below 4", outstanding);
            end
            rid  = 4'($urandom());
            rbt  = 2'($urandom());
            rlen = 4'($urandom());
            if (rbt == 2'b10) rlen = 4'((1 << $urandom_range(1, 4)) - 1);
            send(7'($urandom()), rlen, rbt, $urandom(), rid,
                 ($urandom_range(0, 4) == 0) ? (rid ^ 4'd1) : rid, 1'b1);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        wait_idle();
        for (int k = 0; k < 16; k++) rd_check(7'($urandom()));
        check("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
